// File: rtl/bit32_logic_serial.sv
// Byte-serial 32-bit AND/OR/XOR/NOR unit. A single SLICE-bit slice is reused across the lanes, LSB first.
// Define LOGIC_SERIAL_ZF_EN to build the registered zero flag output zf.
module bit32_logic_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s
`ifdef LOGIC_SERIAL_ZF_EN
  ,
  output logic             zf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   s_q, s_d;
`ifdef LOGIC_SERIAL_ZF_EN
  logic               zf_q, zf_d;
`endif

  function automatic logic [SLICE-1:0] slice_fn(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic [1:0]       f);
    case (f)
      2'b00:   slice_fn = x & y;
      2'b01:   slice_fn = x | y;
      2'b10:   slice_fn = x ^ y;
      default: slice_fn = ~(x | y);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    s_d     = s_q;
`ifdef LOGIC_SERIAL_ZF_EN
    zf_d    = zf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          s_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef LOGIC_SERIAL_ZF_EN
          zf_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        // Constant lane indices keep the slice mux free of variable part-selects.
        for (int i = 0; i < NSLICE; i++) begin
          if (cnt_q == CW'(i)) begin
            s_d[i*SLICE +: SLICE] = slice_fn(a_q[i*SLICE +: SLICE], b_q[i*SLICE +: SLICE], op_q);
          end
        end
        if (cnt_q == CW'(NSLICE - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef LOGIC_SERIAL_ZF_EN
          zf_d    = (s_d == '0);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      s_q     <= '0;
`ifdef LOGIC_SERIAL_ZF_EN
      zf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      s_q     <= s_d;
`ifdef LOGIC_SERIAL_ZF_EN
      zf_q    <= zf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
`ifdef LOGIC_SERIAL_ZF_EN
  assign zf        = zf_q;
`endif

endmodule

// File: tb/tb_bit32_logic_serial.sv
// Directed self-checking bench for bit32_logic_serial with hand-computed results.
// Zero-flag checks are compiled in only when LOGIC_SERIAL_ZF_EN is defined.
module tb_bit32_logic_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
`ifdef LOGIC_SERIAL_ZF_EN
  logic        zf;
`endif

  int testCount = 0;
  int failCount = 0;

  bit32_logic_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
`ifdef LOGIC_SERIAL_ZF_EN
    ,
    .zf        (zf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, observed, expected);
    end
  endtask

  // Present operands and hold in_valid until the accept edge; inputs change 1 time unit after edges.
  task automatic startOp(input logic [31:0] aIn, input logic [31:0] bIn, input logic [1:0] opIn);
    int waitCycles;
    waitCycles = 0;
    while (in_ready !== 1'b1 && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
    a = aIn; b = bIn; op = opIn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("s cleared on accept", s, 32'd0);
    checkOutput("in_ready low in RUN", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic waitDone(output int latency);
    latency = 0;
    while (out_valid !== 1'b1 && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid drops after handshake", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready back in IDLE", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] aIn, input logic [31:0] bIn,
                               input logic [1:0] opIn, input logic [31:0] expS);
    int latency;
    logic [31:0] heldS;
    startOp(aIn, bIn, opIn);
    waitDone(latency);
    checkOutput({tag, " latency"}, latency, 32'd4);
    checkOutput({tag, " result"}, s, expS);
`ifdef LOGIC_SERIAL_ZF_EN
    checkOutput({tag, " zf"}, {31'd0, zf}, {31'd0, (expS == 32'd0)});
`endif
    heldS = s;
    releaseResult();
    checkOutput({tag, " s held in IDLE"}, s, heldS);
  endtask

  initial begin
    int latency;
    logic stableOk;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 2'b01;

    // Reset with in_valid high: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset s", s, 32'd0);
`ifdef LOGIC_SERIAL_ZF_EN
    checkOutput("reset zf", {31'd0, zf}, 32'd0);
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle after reset", {31'd0, in_ready}, 32'd1);

    applyStimulus("AND", 32'hF0F0_1234, 32'hFF00_00FF, 2'b00, 32'hF000_0034);
    applyStimulus("OR",  32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b01, 32'hAFAF_AFAF);
    applyStimulus("XOR", 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b10, 32'hAAAA_AAAA);
    applyStimulus("NOR", 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b11, 32'h5050_5050);
    applyStimulus("AND2", 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b00, 32'h0505_0505);
    applyStimulus("XOR zero", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000);
    applyStimulus("NOR zero", 32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF);

    // Operands change during RUN, then the consumer stalls for 10 cycles.
    startOp(32'h1234_5678, 32'h00FF_FF00, 2'b10);
    a = 32'hFFFF_FFFF; b = 32'h0000_0000; op = 2'b00; in_valid = 1'b1;
    waitDone(latency);
    checkOutput("stall latency", latency, 32'd4);
    checkOutput("latched operands", s, 32'h12CB_A978);
    stableOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || s !== 32'h12CB_A978 || in_ready !== 1'b0) stableOk = 1'b0;
    end
    checkOutput("stable under backpressure", {31'd0, stableOk}, 32'd1);
    in_valid = 1'b0;
    releaseResult();

    // Reset while RUN has cnt=2.
    startOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("partial result present", s, 32'h0000_FFFF);
    rst_n = 1'b0;
    #1;
    checkOutput("midop reset s", s, 32'd0);
    checkOutput("midop reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midop reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stableOk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stableOk = 1'b0;
    end
    checkOutput("no out_valid after abort", {31'd0, stableOk}, 32'd1);
    applyStimulus("post-reset OR", 32'h0000_0001, 32'h0000_0002, 2'b01, 32'h0000_0003);

`ifdef LOGIC_SERIAL_ZF_EN
    applyStimulus("ZF set", 32'h0000_FFFF, 32'hFFFF_0000, 2'b00, 32'h0000_0000);
    applyStimulus("ZF clear", 32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
